// File: rtl/washer_panel_input_pkg.sv
// Shared washer encodings: panel selections and panel FSM states,
// reused by the cycle controller.
package washer_pkg;

  typedef enum logic [1:0] {
    LOAD_SMALL   = 2'b00,
    LOAD_MEDIUM  = 2'b01,
    LOAD_LARGE   = 2'b10,
    LOAD_INVALID = 2'b11
  } load_e;

  typedef enum logic [1:0] {
    TEMP_HOT     = 2'b00,
    TEMP_WARM    = 2'b01,
    TEMP_COLD    = 2'b10,
    TEMP_INVALID = 2'b11
  } temp_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_REQ  = 2'd1,
    P_HOLD = 2'd2
  } panel_state_e;

endpackage

// File: rtl/washer_panel_input_if.sv
// Panel-to-controller link: start handshake, frozen cycle configuration
// and live panel status.
interface washer_panel_if;
  logic       start_req;
  logic       start_ack;
  logic [1:0] cfg_load;
  logic [1:0] cfg_temp;
  logic       cfg_rinse2;
  logic       cfg_spin2;
  logic       lid_open;
  logic       sel_valid;
  logic       err_sticky;

  modport master (
    output start_req, cfg_load, cfg_temp, cfg_rinse2, cfg_spin2,
           lid_open, sel_valid, err_sticky,
    input  start_ack
  );

  modport slave (
    input  start_req, cfg_load, cfg_temp, cfg_rinse2, cfg_spin2,
           lid_open, sel_valid, err_sticky,
    output start_ack
  );
endinterface

// File: rtl/washer_panel_input_debounce.sv
// One panel input: 2-flop synchroniser followed by a stability counter that
// only lets the debounced value follow after DEBOUNCE_CYCLES steady cycles.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 360_000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic [CNT_WIDTH-1:0] cnt;

  // Any return to the stable value restarts the count, so short glitches vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/washer_panel_input.sv
// Front-panel conditioner: debounces switches and start button, validates the
// selection and hands a latched configuration to the cycle controller.
module washer_panel_input
  import washer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 360_000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [6:0]     sw_raw,
  input  logic           start_raw,
  washer_panel_if.master bus
);

  logic [7:0]   raw_in;
  logic [7:0]   deb;
  logic         start_prev;
  logic         press;
  logic         sel_valid_q;
  logic         start_req_q, start_req_next;
  logic         err_q, err_next;
  logic [1:0]   load_q, load_next;
  logic [1:0]   temp_q, temp_next;
  logic         rinse2_q, rinse2_next;
  logic         spin2_q, spin2_next;
  panel_state_e state, state_next;

  assign raw_in = {start_raw, sw_raw};

  for (genvar i = 0; i < 8; i++) begin : g_deb
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (raw_in[i]),
      .dout (deb[i])
    );
  end

  assign press = deb[7] & ~start_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= P_IDLE;
      start_prev  <= 1'b0;
      sel_valid_q <= 1'b0;
      start_req_q <= 1'b0;
      err_q       <= 1'b0;
      load_q      <= '0;
      temp_q      <= '0;
      rinse2_q    <= 1'b0;
      spin2_q     <= 1'b0;
    end else begin
      state       <= state_next;
      start_prev  <= deb[7];
      sel_valid_q <= (deb[1:0] != LOAD_INVALID) && (deb[3:2] != TEMP_INVALID);
      start_req_q <= start_req_next;
      err_q       <= err_next;
      load_q      <= load_next;
      temp_q      <= temp_next;
      rinse2_q    <= rinse2_next;
      spin2_q     <= spin2_next;
    end
  end

  // The ack is checked before the lid so a same-cycle ack still starts the cycle.
  always_comb begin
    state_next     = state;
    start_req_next = start_req_q;
    err_next       = err_q;
    load_next      = load_q;
    temp_next      = temp_q;
    rinse2_next    = rinse2_q;
    spin2_next     = spin2_q;
    case (state)
      P_IDLE: begin
        if (press) begin
          if (sel_valid_q && !deb[6]) begin
            load_next      = deb[1:0];
            temp_next      = deb[3:2];
            rinse2_next    = deb[4];
            spin2_next     = deb[5];
            start_req_next = 1'b1;
            err_next       = 1'b0;
            state_next     = P_REQ;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      P_REQ: begin
        start_req_next = 1'b1;
        if (bus.start_ack) begin
          start_req_next = 1'b0;
          state_next     = P_HOLD;
        end else if (deb[6]) begin
          start_req_next = 1'b0;
          err_next       = 1'b1;
          state_next     = P_IDLE;
        end
      end
      P_HOLD: begin
        start_req_next = 1'b0;
        if (!deb[7]) begin
          state_next = P_IDLE;
        end
      end
      default: begin
        start_req_next = 1'b0;
        state_next     = P_IDLE;
      end
    endcase
  end

  assign bus.start_req  = start_req_q;
  assign bus.cfg_load   = load_q;
  assign bus.cfg_temp   = temp_q;
  assign bus.cfg_rinse2 = rinse2_q;
  assign bus.cfg_spin2  = spin2_q;
  assign bus.lid_open   = deb[6];
  assign bus.sel_valid  = sel_valid_q;
  assign bus.err_sticky = err_q;

endmodule
